// File: rtl/phase_sequencer_if.sv
// Control/status bundle for phase_sequencer.
//   i_RUN, i_SINGLE, i_HOLD, i_RESTART : control levels into the sequencer
//   o_PHASE       : one-hot phase enables (zero when idle)
//   o_STATE       : active phase index (zero when idle)
//   o_BUSY        : sequencer is cycling
//   o_PHASE_LAST  : final clock of a phase that will advance
//   o_CYCLE_START : first clock of phase 0
//   o_CYCLE_COUNT : completed cycles, wrapping
// master = controller side, slave = sequencer side.
interface phase_sequencer_if #(
    parameter int N_PHASES = 3,
    parameter int CNT_W    = 16
);
    logic                          i_RUN;
    logic                          i_SINGLE;
    logic                          i_HOLD;
    logic                          i_RESTART;
    logic [N_PHASES-1:0]           o_PHASE;
    logic [$clog2(N_PHASES)-1:0]   o_STATE;
    logic                          o_BUSY;
    logic                          o_PHASE_LAST;
    logic                          o_CYCLE_START;
    logic [CNT_W-1:0]              o_CYCLE_COUNT;

    modport master (
        output i_RUN, i_SINGLE, i_HOLD, i_RESTART,
        input  o_PHASE, o_STATE, o_BUSY, o_PHASE_LAST, o_CYCLE_START, o_CYCLE_COUNT
    );

    modport slave (
        input  i_RUN, i_SINGLE, i_HOLD, i_RESTART,
        output o_PHASE, o_STATE, o_BUSY, o_PHASE_LAST, o_CYCLE_START, o_CYCLE_COUNT
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-phase cycle generator: N_PHASES non-overlapping one-hot enables,
// each PHASE_LEN clocks long, with run/stop, single-cycle, hold, restart
// and a completed-cycle counter.
//   i_CLOCK : system clock, rising edge
//   i_RESET : asynchronous active-high reset
//   bus     : phase_sequencer_if.slave (controls in, phase/status out)
module phase_sequencer #(
    parameter int N_PHASES  = 3,
    parameter int PHASE_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic               i_CLOCK,
    input  logic               i_RESET,
    phase_sequencer_if.slave   bus
);
    localparam int SW = $clog2(N_PHASES);
    localparam int LW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [SW-1:0] LAST_PH  = SW'(N_PHASES - 1);
    localparam logic [LW-1:0] LAST_SUB = LW'(PHASE_LEN - 1);

    if (N_PHASES < 2 || N_PHASES > 16) begin : g_bad_n
        $error("phase_sequencer: N_PHASES must be 2..16");
    end
    if (PHASE_LEN < 1 || PHASE_LEN > 256) begin : g_bad_len
        $error("phase_sequencer: PHASE_LEN must be 1..256");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("phase_sequencer: CNT_W must be at least 1");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     phase_q, phase_d;
    logic [LW-1:0]     sub_q,   sub_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              cs_q,    cs_d;
    // Set when a cycle ended because of i_SINGLE; blocks a new start until
    // i_SINGLE is released, so holding i_SINGLE high gives exactly one cycle.
    logic              lock_q,  lock_d;

    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q <= IDLE;
            phase_q <= '0;
            sub_q   <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        lock_d  = lock_q;
        if (bus.i_RESTART) begin
            // Abort wins over everything but reset; count is left alone.
            state_d = IDLE;
            phase_d = '0;
            sub_d   = '0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    lock_d = lock_q & bus.i_SINGLE;
                    if (bus.i_RUN && !(lock_q && bus.i_SINGLE)) begin
                        state_d = ACTIVE;
                        phase_d = '0;
                        sub_d   = '0;
                        cs_d    = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!bus.i_HOLD) begin
                        if (sub_q == LAST_SUB) begin
                            sub_d = '0;
                            if (phase_q == LAST_PH) begin
                                // Wrap edge: the only place stop is evaluated.
                                cnt_d   = cnt_q + CNT_W'(1);
                                phase_d = '0;
                                if (!bus.i_RUN || bus.i_SINGLE) begin
                                    state_d = IDLE;
                                    lock_d  = bus.i_SINGLE;
                                end else begin
                                    cs_d = 1'b1;
                                end
                            end else begin
                                phase_d = phase_q + SW'(1);
                            end
                        end else begin
                            sub_d = sub_q + LW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // phase_q is forced to 0 whenever IDLE is entered, so it doubles as o_STATE.
    assign bus.o_BUSY        = (state_q == ACTIVE);
    assign bus.o_PHASE       = (state_q == ACTIVE) ? (N_PHASES'(1) << phase_q) : '0;
    assign bus.o_STATE       = phase_q;
    assign bus.o_PHASE_LAST  = (state_q == ACTIVE) && (sub_q == LAST_SUB) && !bus.i_HOLD;
    assign bus.o_CYCLE_START = cs_q;
    assign bus.o_CYCLE_COUNT = cnt_q;
endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // A: 3 phases x 2 clocks, 16-bit count.  B: 4 phases x 1 clock, 2-bit count.
    phase_sequencer_if #(.N_PHASES(3), .CNT_W(16)) ifa ();
    phase_sequencer_if #(.N_PHASES(4), .CNT_W(2))  ifb ();

    phase_sequencer #(.N_PHASES(3), .PHASE_LEN(2), .CNT_W(16)) dut_a (
        .i_CLOCK(clk), .i_RESET(rst), .bus(ifa));
    phase_sequencer #(.N_PHASES(4), .PHASE_LEN(1), .CNT_W(2)) dut_b (
        .i_CLOCK(clk), .i_RESET(rst), .bus(ifb));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_a(bit r, bit s, bit h, bit rs);
        ifa.i_RUN = r; ifa.i_SINGLE = s; ifa.i_HOLD = h; ifa.i_RESTART = rs;
    endtask
    task automatic drive_b(bit r, bit s, bit h, bit rs);
        ifb.i_RUN = r; ifb.i_SINGLE = s; ifb.i_HOLD = h; ifb.i_RESTART = rs;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        rst = 1'b1;
        next_edge();
        next_edge();
        rst = 1'b0;
    endtask

    // Reference model: position within the cycle (0 .. N*LEN-1) plus a few flags.
    typedef struct {
        bit act;
        int pos;
        int cnt;
        bit fresh;
        bit lock;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t m, int n, int l, bit r, bit s, bit h, bit rs);
        mdl_t x = m;
        x.fresh = 1'b0;
        if (rs) begin
            x.act = 0; x.pos = 0; x.lock = 0;
        end else if (!m.act) begin
            x.lock = m.lock && s;
            if (r && !(m.lock && s)) begin
                x.act = 1; x.pos = 0; x.fresh = 1;
            end
        end else if (!h) begin
            if (m.pos == n * l - 1) begin
                x.cnt = m.cnt + 1;
                x.pos = 0;
                if (!r || s) begin
                    x.act = 0; x.lock = s;
                end else begin
                    x.fresh = 1;
                end
            end else begin
                x.pos = m.pos + 1;
            end
        end
        return x;
    endfunction

    mdl_t m0, m1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= '{default: 0};
            m1 <= '{default: 0};
        end else begin
            m0 <= mstep(m0, 3, 2, ifa.i_RUN, ifa.i_SINGLE, ifa.i_HOLD, ifa.i_RESTART);
            m1 <= mstep(m1, 4, 1, ifb.i_RUN, ifb.i_SINGLE, ifb.i_HOLD, ifb.i_RESTART);
        end
    end

    task automatic cmp_m(string tg, mdl_t m, int n, int l, int w, bit hold,
                         logic [15:0] ph, logic [3:0] st, logic bsy, logic lst,
                         logic cs, logic [15:0] cnt);
        logic [15:0] eph;
        eph = m.act ? 16'(1 << (m.pos / l)) : 16'h0;
        chk({tg, "_phase"}, 32'(ph), 32'(eph));
        chk({tg, "_state"}, 32'(st), m.act ? 32'(m.pos / l) : 32'h0);
        chk({tg, "_busy"},  32'(bsy), 32'(m.act));
        chk({tg, "_last"},  32'(lst), 32'(m.act && (m.pos % l == l - 1) && !hold));
        chk({tg, "_cstart"}, 32'(cs), 32'(m.act && m.fresh));
        chk({tg, "_count"}, 32'(cnt), 32'(m.cnt % (1 << w)));
    endtask

    typedef struct {
        bit       run, single, hold, restart;
        bit [2:0] ph;
        bit       last, cs;
        int       cnt;
    } vec_t;

    vec_t tbl[22];

    initial begin
        bit          found;
        int          busy_n;
        logic [3:0]  seen;

        // inputs {run,single,hold,restart} -> expected {phase,last,cstart,count}
        tbl[0]  = '{1,0,0,0, 3'b000,0,0,0};
        tbl[1]  = '{1,0,0,0, 3'b001,0,1,0};
        tbl[2]  = '{1,0,0,0, 3'b001,1,0,0};
        tbl[3]  = '{1,0,0,0, 3'b010,0,0,0};
        tbl[4]  = '{1,0,0,0, 3'b010,1,0,0};
        tbl[5]  = '{1,0,0,0, 3'b100,0,0,0};
        tbl[6]  = '{1,0,0,0, 3'b100,1,0,0};
        tbl[7]  = '{1,0,0,0, 3'b001,0,1,1};
        tbl[8]  = '{1,0,0,0, 3'b001,1,0,1};
        tbl[9]  = '{1,0,1,0, 3'b010,0,0,1};
        tbl[10] = '{1,0,1,0, 3'b010,0,0,1};
        tbl[11] = '{1,0,1,0, 3'b010,0,0,1};
        tbl[12] = '{1,0,0,0, 3'b010,0,0,1};
        tbl[13] = '{1,0,0,0, 3'b010,1,0,1};
        tbl[14] = '{1,0,0,0, 3'b100,0,0,1};
        tbl[15] = '{0,0,0,0, 3'b100,1,0,1};
        tbl[16] = '{0,0,0,0, 3'b000,0,0,2};
        tbl[17] = '{1,1,1,0, 3'b000,0,0,2};
        tbl[18] = '{1,0,0,0, 3'b001,0,1,2};
        tbl[19] = '{1,0,0,1, 3'b001,1,0,2};
        tbl[20] = '{1,0,0,0, 3'b000,0,0,2};
        tbl[21] = '{1,0,0,0, 3'b001,0,1,2};

        // Reset values, sampled while reset is held.
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        #2;
        chk("rst_phase", 32'(ifa.o_PHASE), 0);
        chk("rst_busy",  32'(ifa.o_BUSY), 0);
        chk("rst_count", 32'(ifa.o_CYCLE_COUNT), 0);
        chk("rst_cstart", 32'(ifa.o_CYCLE_START), 0);

        // Table-driven sweep on A: run, hold, stop, idle hold, restart.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            drive_a(tbl[i].run, tbl[i].single, tbl[i].hold, tbl[i].restart);
            @(negedge clk);
            chk($sformatf("tbl%0d_phase", i), 32'(ifa.o_PHASE), 32'(tbl[i].ph));
            chk($sformatf("tbl%0d_busy", i), 32'(ifa.o_BUSY), 32'(tbl[i].ph != 0));
            chk($sformatf("tbl%0d_last", i), 32'(ifa.o_PHASE_LAST), 32'(tbl[i].last));
            chk($sformatf("tbl%0d_cstart", i), 32'(ifa.o_CYCLE_START), 32'(tbl[i].cs));
            chk($sformatf("tbl%0d_count", i), 32'(ifa.o_CYCLE_COUNT), 32'(tbl[i].cnt));
            next_edge();
        end

        // Single cycle with i_SINGLE held: exactly 6 active clocks.
        do_reset();
        drive_a(1, 1, 0, 0);
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.o_BUSY) busy_n++;
            next_edge();
        end
        chk("single_busy_clocks", 32'(busy_n), 6);
        @(negedge clk);
        chk("single_busy_end", 32'(ifa.o_BUSY), 0);
        chk("single_phase_end", 32'(ifa.o_PHASE), 0);
        chk("single_count", 32'(ifa.o_CYCLE_COUNT), 1);
        next_edge();

        // Restart on the wrap edge at count 4: count must not move.
        do_reset();
        drive_a(1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (ifa.o_CYCLE_COUNT == 4 && ifa.o_STATE == 2 && ifa.o_PHASE_LAST)
                found = 1;
            else
                next_edge();
        end
        chk("restart_reach", 32'(found), 1);
        ifa.i_RESTART = 1'b1;
        next_edge();
        ifa.i_RESTART = 1'b0;
        @(negedge clk);
        chk("restart_phase", 32'(ifa.o_PHASE), 0);
        chk("restart_busy", 32'(ifa.o_BUSY), 0);
        chk("restart_count", 32'(ifa.o_CYCLE_COUNT), 4);
        next_edge();
        @(negedge clk);
        chk("restart_rerun_phase", 32'(ifa.o_PHASE), 1);
        chk("restart_rerun_cstart", 32'(ifa.o_CYCLE_START), 1);
        chk("restart_rerun_count", 32'(ifa.o_CYCLE_COUNT), 4);

        // Asynchronous reset between edges.
        next_edge();
        next_edge();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_phase", 32'(ifa.o_PHASE), 0);
        chk("arst_busy", 32'(ifa.o_BUSY), 0);
        chk("arst_state", 32'(ifa.o_STATE), 0);
        chk("arst_count", 32'(ifa.o_CYCLE_COUNT), 0);
        chk("arst_last", 32'(ifa.o_PHASE_LAST), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_idle", 32'(ifa.o_BUSY), 0);
        next_edge();
        @(negedge clk);
        chk("arst_rel_phase", 32'(ifa.o_PHASE), 1);
        chk("arst_rel_cstart", 32'(ifa.o_CYCLE_START), 1);

        // B: 2-bit counter wrap over 5 back-to-back cycles.
        do_reset();
        drive_b(1, 0, 0, 0);
        next_edge();
        for (int c = 0; c < 5; c++) begin
            repeat (4) @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("b_count%0d", c), 32'(ifb.o_CYCLE_COUNT), 32'((c + 1) % 4));
            chk($sformatf("b_cstart%0d", c), 32'(ifb.o_CYCLE_START), 1);
        end
        // Drop run right after phase 0: the cycle still completes.
        seen = ifb.o_PHASE;
        next_edge();
        ifb.i_RUN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifb.o_BUSY) seen |= ifb.o_PHASE;
            next_edge();
        end
        chk("b_drop_all_phases", 32'(seen), 32'hF);
        @(negedge clk);
        chk("b_drop_idle", 32'(ifb.o_BUSY), 0);
        chk("b_drop_phase", 32'(ifb.o_PHASE), 0);
        chk("b_drop_count", 32'(ifb.o_CYCLE_COUNT), 2);
        next_edge();

        // Randomized run of both instances against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_a($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 6) == 0, $urandom_range(0, 39) == 0);
            drive_b($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0);
            @(negedge clk);
            cmp_m("rndA", m0, 3, 2, 16, ifa.i_HOLD, 16'(ifa.o_PHASE), 4'(ifa.o_STATE),
                  ifa.o_BUSY, ifa.o_PHASE_LAST, ifa.o_CYCLE_START, 16'(ifa.o_CYCLE_COUNT));
            cmp_m("rndB", m1, 4, 1, 2, ifb.i_HOLD, 16'(ifb.o_PHASE), 4'(ifb.o_STATE),
                  ifb.o_BUSY, ifb.o_PHASE_LAST, ifb.o_CYCLE_START, 16'(ifb.o_CYCLE_COUNT));
            if (n_err > 50) break;
            next_edge();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised multi-phase cycle generator and successor to the fixed three-phase divider. It produces N non-overlapping one-hot phase enables, each lasting PHASE_LEN clocks. It adds run/stop control, single-cycle stepping, hold (stall), synchronous restart and a completed-cycle counter. It sits beside the CPU datapath and sequences fetch/decode/execute-style phases for downstream blocks.

Parameters:
N_PHASES, 3, number of phases per cycle; legal range 2..16.
PHASE_LEN, 1, clocks each phase stays asserted; legal range 1..256.
CNT_W, 16, width of completed-cycle counter.

Ports:
i_CLOCK  input  1  single system clock; all state changes on its rising edge.
i_RESET  input  1  asynchronous, active-high reset.
i_RUN  input  1  level; 1 = keep cycling; 0 = stop at end of current cycle.
i_SINGLE  input  1  level; 1 = stop after current cycle completes even if i_RUN=1.
i_HOLD  input  1  level; freezes phase and sub-count while 1.
i_RESTART  input  1  synchronous abort; returns to IDLE.
o_PHASE  output  N_PHASES  one-hot phase enable; all zero in IDLE.
o_STATE  output  clog2(N_PHASES)  index of active phase; 0 in IDLE.
o_BUSY  output  1  1 while in ACTIVE.
o_PHASE_LAST  output  1  1 during the final clock of a phase that will advance (sub==PHASE_LEN-1 and !i_HOLD).
o_CYCLE_START  output  1  one-clock pulse coincident with the first clock of phase 0.
o_CYCLE_COUNT  output  CNT_W  number of completed cycles, modulo 2^CNT_W.

Behaviour:
- Reset (async, i_RESET=1): FSM=IDLE, phase index=0, sub-count=0, o_PHASE=0, o_STATE=0, o_BUSY=0, o_PHASE_LAST=0, o_CYCLE_START=0, o_CYCLE_COUNT=0. Outputs take these values immediately on assertion, without waiting for a clock edge.
- States: IDLE, ACTIVE. All outputs are registered or decoded from registers; none are combinational from inputs, except o_PHASE_LAST, which uses i_HOLD.
- IDLE: if i_RUN=1 at an edge, enter ACTIVE with phase=0, sub=0. The first ACTIVE clock shows o_PHASE=1 (bit 0) and o_CYCLE_START=1. Latency from i_RUN to phase 0 is one clock.
- ACTIVE, with !i_HOLD:
  - sub increments each clock.
  - At sub==PHASE_LEN-1: sub returns to 0 and phase advances to phase+1.
- ACTIVE, phase wrap: at the last clock of phase N_PHASES-1, o_CYCLE_COUNT increments, wrapping at 2^CNT_W.
  - If i_RUN=0 or i_SINGLE=1 sampled on that edge: go to IDLE, o_PHASE=0.
  - Otherwise: go to phase 0 with o_CYCLE_START pulse.
  - Back-to-back cycles have no idle gap.
- i_RUN dropping mid-cycle: the current cycle completes in full. Stop is only evaluated at the wrap edge.
- i_HOLD=1:
  - phase, sub and o_PHASE are frozen; the current phase stays asserted.
  - o_PHASE_LAST=0 and o_CYCLE_START is not re-pulsed.
  - Hold in IDLE has no effect; the i_RUN start still proceeds.
- i_RESTART=1 at an edge: next state IDLE, phase=0, sub=0, o_PHASE=0. o_CYCLE_COUNT is unchanged and not incremented, even on a wrap edge. i_RUN is re-evaluated from IDLE on the following edge.
- Priority: i_RESET > i_RESTART > i_HOLD > normal advance/stop.
- PHASE_LEN=1: each phase lasts exactly one clock. o_PHASE_LAST=1 on every non-held ACTIVE clock.
- Invariant: o_PHASE is one-hot in ACTIVE, zero in IDLE, and never has two bits set.
- Reset released mid-operation: the block restarts from IDLE. The first phase appears one clock after an edge where i_RUN=1.
- Elaboration must fail (generate-time error) for parameters outside the legal ranges.

Test Plan:
- N_PHASES=3, PHASE_LEN=2, i_RUN held 1 from reset release -> o_PHASE follows 001,001,010,010,100,100,001,... and o_CYCLE_START pulses every 6 clocks; o_CYCLE_COUNT=2 after 12 ACTIVE clocks.
- Same config, i_SINGLE=1 with i_RUN=1 -> exactly 6 ACTIVE clocks, then o_BUSY=0, o_PHASE=000, o_CYCLE_COUNT=1; no further phases while i_SINGLE stays 1.
- i_HOLD=1 for 3 clocks during the first clock of phase 1 -> o_PHASE=010 for 5 consecutive clocks, o_PHASE_LAST=0 while held, cycle length becomes 9.
- i_RESTART pulsed during phase 2 with o_CYCLE_COUNT=4 -> o_PHASE=000 next clock, count stays 4, phase 0 plus o_CYCLE_START one clock later with i_RUN=1.
- i_RESET asserted asynchronously mid-phase (between edges) -> all outputs zero before the next edge; after release with i_RUN=1, phase 0 appears one clock later.
- CNT_W=2, i_RUN=1 for 5 cycles -> o_CYCLE_COUNT sequence 1,2,3,0,1; with N_PHASES=4, PHASE_LEN=1, i_RUN dropped mid-cycle -> all 4 phases still appear before IDLE.
